score_ctl: RTL and testbench

Match scorekeeper sitting directly upstream of the win/lose overlay stage: converts goal indications from the ball logic into the two 2-bit scores that overlay consumes, and runs the match flow (serve delay, game over, restart). Goals are edge-detected, scores saturate at the win value, the serve delay is counted in frames from vsync, and a debounced restart button clears the match.

---
 rtl/score_ctl.sv | 74 +++++++
 tb/tb_score_ctl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/score_ctl.sv
// score_ctl: match scorekeeper with goal edge detect, frame-counted serve delay and debounced restart
module score_ctl #(
  parameter int WIN_SCORE       = 3,
  parameter int SERVE_FRAMES    = 60,
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       btn_restart,
  output logic [1:0] score_p1,
  output logic [1:0] score_p2,
  output logic       ball_hold,
  output logic       game_over
);
  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;
  localparam logic [1:0]  WIN = 2'(WIN_SCORE);
  localparam logic [7:0]  SF  = 8'(SERVE_FRAMES);
  localparam logic [19:0] DB  = 20'(DEBOUNCE_CYCLES);
  state_t st, st_n;
  logic [7:0] fc, fc_n;
  logic [1:0] s1_n, s2_n;
  logic [19:0] db;
  logic g1, g1_q, g2, g2_q, vs, vs_q, b1, b2;
  logic e1, e2, ev, press;
  assign e1 = g1 & ~g1_q;
  assign e2 = g2 & ~g2_q;
  assign ev = vs & ~vs_q;
  assign press = b2 && db == DB - 20'd1;
  always_ff @(posedge pclk) begin
    if (!rst) begin
      {g1, g1_q, g2, g2_q, vs, vs_q, b1, b2} <= '0;
      db        <= '0;
      st        <= SERVE;
      fc        <= SF;
      score_p1  <= '0;
      score_p2  <= '0;
      ball_hold <= 1'b1;
      game_over <= 1'b0;
    end else begin
      {g1, g1_q, g2, g2_q, vs, vs_q} <= {goal_p1, g1, goal_p2, g2, vsync_in, vs};
      {b1, b2}  <= {btn_restart, b1};
      db        <= !b2 ? 20'd0 : db == DB ? db : db + 20'd1;
      st        <= st_n;
      fc        <= fc_n;
      score_p1  <= s1_n;
      score_p2  <= s2_n;
      ball_hold <= st_n != PLAY;
      game_over <= st_n == OVER;
    end
  end
  always_comb begin
    st_n = st;
    fc_n = fc;
    s1_n = score_p1;
    s2_n = score_p2;
    if (press) begin
      st_n = SERVE;
      fc_n = SF;
      s1_n = '0;
      s2_n = '0;
    end else if (st == PLAY && (e1 || e2)) begin
      s1_n = score_p1 + 2'(e1);
      s2_n = score_p2 + 2'(!e1);
      st_n = ((e1 ? s1_n : s2_n) == WIN) ? OVER : SERVE;
      fc_n = SF;
    end else if (st == SERVE && ev) begin
      fc_n = fc - 8'd1;
      st_n = fc == 8'd1 ? PLAY : SERVE;
    end
  end
endmodule

// File: tb/tb_score_ctl.sv
// tb_score_ctl: vector table, directed corner sequences and random stimulus against a history-based reference model
module tb_score_ctl;
  localparam int WIN = 3, SF = 2, DB = 4;
  logic pclk = 0, rst = 0, vsync_in = 0, goal_p1 = 0, goal_p2 = 0, btn_restart = 0;
  logic [1:0] score_p1, score_p2;
  logic ball_hold, game_over;
  int tests = 0, fails = 0;
  int m_s1 = 0, m_s2 = 0, m_mode = 0, m_fr = SF, runa = 0, runb = 0;
  bit h1a, h1b, h2a, h2b, hva, hvb;

  score_ctl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .DEBOUNCE_CYCLES(DB)) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .goal_p1(goal_p1), .goal_p2(goal_p2),
    .btn_restart(btn_restart), .score_p1(score_p1), .score_p2(score_p2),
    .ball_hold(ball_hold), .game_over(game_over));

  always #5 pclk = ~pclk;

  typedef struct {
    bit r, a, b, v, bt;
    int s1, s2;
    bit hold, over;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 serve, 1 play, 2 over; press when the button has been seen high for exactly DB samples, two samples ago
  task automatic model(input bit r, input bit a, input bit b, input bit v, input bit bt);
    bit e1, e2, ev;
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_mode = 0; m_fr = SF;
      {h1a, h1b, h2a, h2b, hva, hvb} = '0;
      runa = 0; runb = 0;
    end else begin
      e1 = h1a && !h1b;
      e2 = h2a && !h2b;
      ev = hva && !hvb;
      if (runb == DB) begin
        m_s1 = 0; m_s2 = 0; m_mode = 0; m_fr = SF;
      end else if (m_mode == 1 && (e1 || e2)) begin
        if (e1) m_s1++; else m_s2++;
        m_mode = ((e1 ? m_s1 : m_s2) == WIN) ? 2 : 0;
        m_fr = SF;
      end else if (m_mode == 0 && ev) begin
        m_fr--;
        if (m_fr == 0) m_mode = 1;
      end
      h1b = h1a; h1a = a;
      h2b = h2a; h2a = b;
      hvb = hva; hva = v;
      runb = runa; runa = bt ? runa + 1 : 0;
    end
  endtask

  task automatic step(input bit r, input bit a, input bit b, input bit v, input bit bt);
    rst = r; goal_p1 = a; goal_p2 = b; vsync_in = v; btn_restart = bt;
    @(posedge pclk);
    #1;
    model(r, a, b, v, bt);
    chk("model_score_p1", int'(score_p1), m_s1);
    chk("model_score_p2", int'(score_p2), m_s2);
    chk("model_ball_hold", int'(ball_hold), int'(m_mode != 1));
    chk("model_game_over", int'(game_over), int'(m_mode == 2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic serve();
    step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t tbl[10];
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[2] = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[3] = '{1, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[4] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 0, 0, 1, 0, 1, 0};
    tbl[7] = '{1, 1, 0, 0, 0, 1, 0, 1, 0};
    tbl[8] = '{1, 0, 1, 0, 0, 1, 0, 1, 0};
    tbl[9] = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].bt);
      chk($sformatf("vec%0d_score_p1", i), int'(score_p1), tbl[i].s1);
      chk($sformatf("vec%0d_score_p2", i), int'(score_p2), tbl[i].s2);
      chk($sformatf("vec%0d_ball_hold", i), int'(ball_hold), int'(tbl[i].hold));
      chk($sformatf("vec%0d_game_over", i), int'(game_over), int'(tbl[i].over));
    end
    for (int i = 0; i < 50; i++) step(1, 1, 0, 0, 0);
    chk("held_goal_single_inc", int'(score_p1), 1);
    step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    chk("serve_goal_ignored", int'(score_p1), 1);
    serve();
    chk("in_play", int'(ball_hold), 0);
    step(1, 1, 1, 0, 0); step(1, 0, 0, 0, 0);
    chk("tie_p1", int'(score_p1), 2);
    chk("tie_p2", int'(score_p2), 0);
    for (int g = 0; g < 3; g++) begin
      serve();
      step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
    end
    chk("win_p2", int'(score_p2), 3);
    chk("win_over", int'(game_over), 1);
    chk("win_hold", int'(ball_hold), 1);
    for (int g = 0; g < 2; g++) begin
      step(1, 0, 1, 1, 0); step(1, 0, 0, 0, 0);
    end
    chk("over_sat_p2", int'(score_p2), 3);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    idle(4);
    chk("short_press_over", int'(game_over), 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1);
    idle(3);
    chk("restart_over", int'(game_over), 0);
    chk("restart_p2", int'(score_p2), 0);
    chk("restart_hold", int'(ball_hold), 1);
    serve();
    chk("restart_serve_reload", int'(ball_hold), 0);
    step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    serve();
    step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    serve();
    chk("pre_reset_p1", int'(score_p1), 2);
    step(0, 0, 0, 0, 0);
    chk("mid_reset_p1", int'(score_p1), 0);
    chk("mid_reset_hold", int'(ball_hold), 1);
    begin
      bit a = 0, b = 0, bt = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(7) == 0) a = !a;
        if ($urandom_range(7) == 0) b = !b;
        if ($urandom_range(5) == 0) bt = !bt;
        step($urandom_range(255) != 0, a, b, $urandom_range(2) == 0, bt);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
